// File: rtl/gate_test_pkg.sv
// ============================================================================
//  Module   : gate_test_pkg
//  Purpose  : Shared FSM states, vector count and fail_mask bit positions
//             for the gate test sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package gate_test_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int NUM_VECTORS = 4;

  localparam int FAIL_AND_BIT  = 0;
  localparam int FAIL_OR_BIT   = 1;
  localparam int FAIL_NAND_BIT = 2;
  localparam int FAIL_NOR_BIT  = 3;
  localparam int FAIL_XOR_BIT  = 4;

  // Places the five gate results in fail_mask bit order.
  function automatic logic [4:0] pack_gates(
    input logic and_v,
    input logic or_v,
    input logic nand_v,
    input logic nor_v,
    input logic xor_v
  );
    logic [4:0] v;
    v                = '0;
    v[FAIL_AND_BIT]  = and_v;
    v[FAIL_OR_BIT]   = or_v;
    v[FAIL_NAND_BIT] = nand_v;
    v[FAIL_NOR_BIT]  = nor_v;
    v[FAIL_XOR_BIT]  = xor_v;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_ref_model.sv
// ============================================================================
//  Module   : gate_ref_model
//  Purpose  : Combinational golden results of the five two-input gates.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_ref_model (
  input  logic a,
  input  logic b,
  output logic and_ref,
  output logic or_ref,
  output logic nand_ref,
  output logic nor_ref,
  output logic xor_ref
);

  assign and_ref  = a & b;
  assign or_ref   = a | b;
  assign nand_ref = ~(a & b);
  assign nor_ref  = ~(a | b);
  assign xor_ref  = a ^ b;

endmodule

`default_nettype wire

// File: rtl/gate_test_sequencer.sv
// ============================================================================
//  Module   : gate_test_sequencer
//  Purpose  : Sweeps {a,b} through 00..11, checks a gate block against a
//             golden model and reports errors. Optional first-failure capture
//             is enabled by defining GATE_TEST_SEQUENCER_FAIL_LOG_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       nand_in,
  input  logic       nor_in,
  input  logic       xor_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [4:0] fail_mask
`ifdef GATE_TEST_SEQUENCER_FAIL_LOG_EN
  ,
  output logic [1:0] first_fail_vec,
  output logic       first_fail_valid
`endif
);

  localparam logic [1:0] c_last_vec    = 2'(NUM_VECTORS - 1);
  localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_vec;
  logic [3:0] r_settle_cnt;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err;
  logic [4:0] r_mask;

  logic       w_and_ref, w_or_ref, w_nand_ref, w_nor_ref, w_xor_ref;
  logic [4:0] w_mismatch;
  logic       w_vec_fail;
  logic [2:0] w_err_next;

  gate_ref_model u_ref (
    .a        (r_vec[1]),
    .b        (r_vec[0]),
    .and_ref  (w_and_ref),
    .or_ref   (w_or_ref),
    .nand_ref (w_nand_ref),
    .nor_ref  (w_nor_ref),
    .xor_ref  (w_xor_ref)
  );

  assign w_mismatch = pack_gates(and_in, or_in, nand_in, nor_in, xor_in)
                    ^ pack_gates(w_and_ref, w_or_ref, w_nand_ref, w_nor_ref, w_xor_ref);
  assign w_vec_fail = |w_mismatch;
  // One count per failing vector, however many gates disagree.
  assign w_err_next = r_err + {2'b00, w_vec_fail};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_vec        <= 2'b00;
      r_settle_cnt <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= 3'd0;
      r_mask       <= 5'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= DRIVE;
            r_vec   <= 2'b00;
            r_err   <= 3'd0;
            r_mask  <= 5'd0;
            r_pass  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        DRIVE: begin
          r_settle_cnt <= 4'd0;
          r_state      <= (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
        end
        SETTLE: begin
          if (r_settle_cnt == c_settle_last) begin
            r_state <= CHECK;
          end else begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        CHECK: begin
          r_mask <= r_mask | w_mismatch;
          r_err  <= w_err_next;
          if (r_vec == c_last_vec) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 3'd0);
          end else begin
            r_vec   <= r_vec + 2'd1;
            r_state <= DRIVE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign a         = r_vec[1];
  assign b         = r_vec[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_mask = r_mask;

`ifdef GATE_TEST_SEQUENCER_FAIL_LOG_EN
  logic [1:0] r_ff_vec;
  logic       r_ff_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ff_vec   <= 2'b00;
      r_ff_valid <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_ff_vec   <= 2'b00;
      r_ff_valid <= 1'b0;
    end else if (r_state == CHECK && w_vec_fail && !r_ff_valid) begin
      r_ff_vec   <= r_vec;
      r_ff_valid <= 1'b1;
    end
  end

  assign first_fail_vec   = r_ff_vec;
  assign first_fail_valid = r_ff_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gate_test_sequencer.sv
// ============================================================================
//  Module   : tb_gate_test_sequencer
//  Purpose  : Self-checking bench for gate_test_sequencer (SETTLE_CYCLES 2 and 0).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start2, start0;
  logic sel0;
  logic force_xor0, force_and1;

  logic       a2, b2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [4:0] mask2;
  logic       a0, b0, busy0, done0, pass0;
  logic [2:0] err0;
  logic [4:0] mask0;
  logic [4:0] g2, g0;
`ifdef GATE_TEST_SEQUENCER_FAIL_LOG_EN
  logic [1:0] ffv2, ffv0;
  logic       ffok2, ffok0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         busy_len;
    logic [2:0] err;
    logic [4:0] mask;
    logic       pass;
    logic [1:0] ffv;
    logic       ffvalid;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Gate block under test, with optional stuck-at faults; bit order AND,OR,NAND,NOR,XOR.
  function automatic logic [4:0] gate_vals(input logic a, input logic b,
                                           input logic fx, input logic fa);
    logic [4:0] g;
    g = {a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    if (fx) g[4] = 1'b0;
    if (fa) g[0] = 1'b1;
    return g;
  endfunction

  assign g2 = gate_vals(a2, b2, force_xor0, force_and1);
  assign g0 = gate_vals(a0, b0, force_xor0, force_and1);

  gate_test_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .and_in(g2[0]), .or_in(g2[1]), .nand_in(g2[2]), .nor_in(g2[3]), .xor_in(g2[4]),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_mask(mask2)
`ifdef GATE_TEST_SEQUENCER_FAIL_LOG_EN
    , .first_fail_vec(ffv2), .first_fail_valid(ffok2)
`endif
  );

  gate_test_sequencer #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
    .and_in(g0[0]), .or_in(g0[1]), .nand_in(g0[2]), .nor_in(g0[3]), .xor_in(g0[4]),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_mask(mask0)
`ifdef GATE_TEST_SEQUENCER_FAIL_LOG_EN
    , .first_fail_vec(ffv0), .first_fail_valid(ffok0)
`endif
  );

  logic       m_busy, m_done, m_pass;
  logic [1:0] m_ab;
  logic [2:0] m_err;
  logic [4:0] m_mask;
  assign m_busy = sel0 ? busy0 : busy2;
  assign m_done = sel0 ? done0 : done2;
  assign m_pass = sel0 ? pass0 : pass2;
  assign m_ab   = sel0 ? {a0, b0} : {a2, b2};
  assign m_err  = sel0 ? err0 : err2;
  assign m_mask = sel0 ? mask0 : mask2;
`ifdef GATE_TEST_SEQUENCER_FAIL_LOG_EN
  logic [1:0] m_ffv;
  logic       m_ffok;
  assign m_ffv  = sel0 ? ffv0 : ffv2;
  assign m_ffok = sel0 ? ffok0 : ffok2;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_expected(input int settle);
    exp_t e;
    logic [1:0] v;
    logic [4:0] d;
    e.busy_len = 4 * (2 + settle);
    e.err = 3'd0; e.mask = 5'd0; e.ffv = 2'b00; e.ffvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      d = gate_vals(v[1], v[0], 1'b0, 1'b0) ^ gate_vals(v[1], v[0], force_xor0, force_and1);
      if (d != 5'd0) begin
        e.err = e.err + 3'd1;
        if (!e.ffvalid) begin e.ffvalid = 1'b1; e.ffv = v; end
      end
      e.mask = e.mask | d;
    end
    e.pass = (e.err == 3'd0);
    sb.push_back(e);
  endtask

  task automatic set_start(input logic v);
    if (sel0) start0 = v; else start2 = v;
  endtask

  task automatic run_sweep(input string name);
    int   cnt, guard;
    exp_t e;
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    cnt = 0; guard = 0;
    while (m_done !== 1'b1 && guard < 300) begin
      if (m_busy === 1'b1) cnt++;
      guard++;
      @(negedge clk);
    end
    n_tests++;
    if (m_done !== 1'b1) begin n_fail++; $display("FAIL %s done_seen: got %b want 1", name, m_done); end
    e = sb.pop_front();
    n_tests++;
    if (cnt != e.busy_len) begin n_fail++; $display("FAIL %s busy_len: got %0d want %0d", name, cnt, e.busy_len); end
    n_tests++;
    if (m_busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_in_done: got %b want 0", name, m_busy); end
    @(negedge clk);
    n_tests++;
    if (m_done !== 1'b0) begin n_fail++; $display("FAIL %s done_width: got %b want 0", name, m_done); end
    n_tests++;
    if (m_err !== e.err) begin n_fail++; $display("FAIL %s err_count: got %0d want %0d", name, m_err, e.err); end
    n_tests++;
    if (m_mask !== e.mask) begin n_fail++; $display("FAIL %s fail_mask: got %b want %b", name, m_mask, e.mask); end
    n_tests++;
    if (m_pass !== e.pass) begin n_fail++; $display("FAIL %s pass: got %b want %b", name, m_pass, e.pass); end
    n_tests++;
    if (m_ab !== 2'b11) begin n_fail++; $display("FAIL %s ab_hold: got %b want 11", name, m_ab); end
`ifdef GATE_TEST_SEQUENCER_FAIL_LOG_EN
    n_tests++;
    if (m_ffok !== e.ffvalid) begin n_fail++; $display("FAIL %s ff_valid: got %b want %b", name, m_ffok, e.ffvalid); end
    if (e.ffvalid) begin
      n_tests++;
      if (m_ffv !== e.ffv) begin n_fail++; $display("FAIL %s ff_vec: got %b want %b", name, m_ffv, e.ffv); end
    end
`endif
  endtask

  task automatic test_reset();
    n_tests++;
    if ({a2, b2, busy2, done2, pass2, err2, mask2} !== 13'd0) begin
      n_fail++; $display("FAIL reset_dut2: got %b want 0", {a2, b2, busy2, done2, pass2, err2, mask2});
    end
    n_tests++;
    if ({a0, b0, busy0, done0, pass0, err0, mask0} !== 13'd0) begin
      n_fail++; $display("FAIL reset_dut0: got %b want 0", {a0, b0, busy0, done0, pass0, err0, mask0});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy2, done2, busy0, done0} !== 4'd0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 0000", {busy2, done2, busy0, done0});
    end
  endtask

  task automatic test_clean();
    sel0 = 1'b0; force_xor0 = 1'b0; force_and1 = 1'b0;
    push_expected(2);
    run_sweep("clean");
  endtask

  task automatic test_xor_stuck();
    sel0 = 1'b0; force_xor0 = 1'b1; force_and1 = 1'b0;
    push_expected(2);
    run_sweep("xor_stuck0");
    force_xor0 = 1'b0;
  endtask

  task automatic test_and_stuck();
    sel0 = 1'b0; force_xor0 = 1'b0; force_and1 = 1'b1;
    push_expected(2);
    run_sweep("and_stuck1");
    force_and1 = 1'b0;
  endtask

  task automatic test_settle0();
    sel0 = 1'b1; force_xor0 = 1'b0; force_and1 = 1'b0;
    push_expected(0);
    run_sweep("settle0");
    sel0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int guard;
    sel0 = 1'b0; force_xor0 = 1'b1;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    guard = 0;
    while ({a2, b2} !== 2'b10 && guard < 100) begin @(negedge clk); guard++; end
    n_tests++;
    if ({a2, b2} !== 2'b10) begin n_fail++; $display("FAIL mid_reach_10: got %b want 10", {a2, b2}); end
    n_tests++;
    if (err2 !== 3'd1) begin n_fail++; $display("FAIL mid_err_before_rst: got %0d want 1", err2); end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({a2, b2, busy2, done2, pass2, err2, mask2} !== 13'd0) begin
      n_fail++; $display("FAIL mid_reset_async: got %b want 0", {a2, b2, busy2, done2, pass2, err2, mask2});
    end
`ifdef GATE_TEST_SEQUENCER_FAIL_LOG_EN
    n_tests++;
    if (ffok2 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ff_valid: got %b want 0", ffok2); end
`endif
    @(negedge clk); rst = 1'b0; force_xor0 = 1'b0;
    push_expected(2);
    run_sweep("after_mid_reset");
  endtask

  task automatic test_back_to_back();
    logic [39:0] bs, ds;
    int   bad_b, bad_d, guard;
    exp_t e;
    sel0 = 1'b0;
    push_expected(2);
    push_expected(2);
    @(negedge clk); start2 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bs[i] = busy2; ds[i] = done2;
      if (done2 === 1'b1) begin
        e = sb.pop_front();
        n_tests++;
        if (err2 !== e.err) begin n_fail++; $display("FAIL b2b_err sample %0d: got %0d want %0d", i, err2, e.err); end
      end
    end
    start2 = 1'b0;
    // 16 busy samples, one DONE, one IDLE, then the next sweep.
    bad_b = 0; bad_d = 0;
    for (int i = 0; i < 40; i++) begin
      if (bs[i] !== ((i % 18) < 16)) bad_b++;
      if (ds[i] !== ((i % 18) == 16)) bad_d++;
    end
    n_tests++;
    if (bad_b != 0) begin n_fail++; $display("FAIL b2b_busy_pattern: got %b mismatching %0d samples want 0", bs, bad_b); end
    n_tests++;
    if (bad_d != 0) begin n_fail++; $display("FAIL b2b_done_pattern: got %b mismatching %0d samples want 0", ds, bad_d); end
    push_expected(2);
    guard = 0;
    while (done2 !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    e = sb.pop_front();
    n_tests++;
    if (done2 !== 1'b1 || err2 !== e.err) begin
      n_fail++; $display("FAIL b2b_third_sweep: got done=%b err=%0d want done=1 err=%0d", done2, err2, e.err);
    end
    @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size()); end
  endtask

  initial begin
    rst = 1'b1; start2 = 1'b0; start0 = 1'b0; sel0 = 1'b0;
    force_xor0 = 1'b0; force_and1 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_clean();
    test_xor_stuck();
    test_and_stuck();
    test_settle0();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
